// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding flits to a UART serializer,
// with a done-timeout and an enforced inter-frame gap.
package types;
    typedef logic [7:0] flit_t;
endpackage

module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IW            = $clog2(NUM_REQ)
) (
    input  logic                        uart_clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_vld,
    input  types::flit_t [NUM_REQ-1:0]  req_flit,
    output logic [NUM_REQ-1:0]          req_rdy,
    output types::flit_t                tx_flit,
    output logic                        tx_vld,
    input  logic                        tx_rdy,
    input  logic                        tx_done,
    output logic [IW-1:0]               grant_id,
    output logic                        busy,
    output logic                        timeout_err
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, GAP} state_t;

    localparam logic [15:0] GAP_LOAD = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam state_t      DONE_ST  = (GAP_CYCLES == 0) ? IDLE : GAP;

    state_t       state_q, state_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [IW-1:0] last_grant_q, last_grant_d;
    logic [IW-1:0] grant_id_q, grant_id_d;
    types::flit_t tx_flit_q, tx_flit_d;
    logic         tx_vld_q, tx_vld_d;
    logic         timeout_err_q, timeout_err_d;
    logic [IW-1:0] winner;
    logic         found;

    // first requesting index after the last grant, wrapping modulo NUM_REQ
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_vld[IW'((int'(last_grant_q) + k) % NUM_REQ)]) begin
                winner = IW'((int'(last_grant_q) + k) % NUM_REQ);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_grant_d  = last_grant_q;
        grant_id_d    = grant_id_q;
        tx_flit_d     = tx_flit_q;
        tx_vld_d      = tx_vld_q;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: if (found) begin
                state_d      = SEND;
                tx_flit_d    = req_flit[winner];
                tx_vld_d     = 1'b1;
                last_grant_d = winner;
                grant_id_d   = winner;
                cnt_d        = '0;
            end
            SEND: if (tx_rdy) begin
                tx_vld_d = 1'b0;
                state_d  = tx_done ? DONE_ST : WAIT_DONE;
                cnt_d    = tx_done ? GAP_LOAD : 16'd0;
            end
            WAIT_DONE: if (tx_done) begin
                state_d = DONE_ST;
                cnt_d   = GAP_LOAD;
            end else if (cnt_q == TO_LAST) begin
                state_d       = IDLE;
                timeout_err_d = 1'b1;
                cnt_d         = '0;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
            GAP: if (cnt_q == 16'd0) state_d = IDLE;
                 else cnt_d = cnt_q - 16'd1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            last_grant_q  <= IW'(NUM_REQ - 1);
            grant_id_q    <= '0;
            tx_flit_q     <= '0;
            tx_vld_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_grant_q  <= last_grant_d;
            grant_id_q    <= grant_id_d;
            tx_flit_q     <= tx_flit_d;
            tx_vld_q      <= tx_vld_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign req_rdy     = (state_q == IDLE && found) ? {{(NUM_REQ-1){1'b0}}, 1'b1} << winner : '0;
    assign tx_flit     = tx_flit_q;
    assign tx_vld      = tx_vld_q;
    assign grant_id    = grant_id_q;
    assign busy        = state_q != IDLE;
    assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scoreboard bench; u0 has a 2-cycle gap and
// 16-cycle timeout, u1 has no gap.
module tb_uart_tx_arbiter;
    localparam int GAP = 2;

    typedef struct {
        int           id;
        types::flit_t flit;
    } sb_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [3:0]         req_vld = '0;
    types::flit_t [3:0] req_flit = '0;
    logic [3:0]         req_rdy;
    types::flit_t       tx_flit;
    logic               tx_vld;
    logic               tx_rdy = 1'b0;
    logic               tx_done = 1'b0;
    logic [1:0]         grant_id;
    logic               busy;
    logic               timeout_err;

    logic [3:0]         r1_vld = '0;
    types::flit_t [3:0] r1_flit = '0;
    logic [3:0]         r1_rdy;
    types::flit_t       r1_tx_flit;
    logic               r1_tx_vld;
    logic               r1_tx_rdy = 1'b0;
    logic               r1_tx_done = 1'b0;
    logic [1:0]         r1_grant_id;
    logic               r1_busy;
    logic               r1_timeout_err;

    int  checks = 0;
    int  errors = 0;
    int  mdl_last = 3;
    sb_t sb[$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(16)) u0 (
        .uart_clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_flit(req_flit),
        .req_rdy(req_rdy), .tx_flit(tx_flit), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
        .tx_done(tx_done), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(16)) u1 (
        .uart_clk(clk), .rst_n(rst_n), .req_vld(r1_vld), .req_flit(r1_flit),
        .req_rdy(r1_rdy), .tx_flit(r1_tx_flit), .tx_vld(r1_tx_vld), .tx_rdy(r1_tx_rdy),
        .tx_done(r1_tx_done), .grant_id(r1_grant_id), .busy(r1_busy), .timeout_err(r1_timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] v);
        for (int k = 1; k <= 4; k++)
            if (v[2'((mdl_last + k) % 4)]) return (mdl_last + k) % 4;
        return 0;
    endfunction

    task automatic push_grant(input logic [3:0] v);
        int w;
        w = pick(v);
        chk("grant_rdy", 32'(req_rdy), 32'(1) << w);
        sb.push_back('{id: w, flit: req_flit[2'(w)]});
        mdl_last = w;
    endtask

    task automatic pop_check();
        sb_t e;
        chk("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_flit", 32'(tx_flit), 32'(e.flit));
            chk("sb_grant_id", 32'(grant_id), e.id);
        end
    endtask

    // Starts at an idle negedge; ends at the first idle negedge after the gap.
    task automatic frame(input logic [3:0] vld, input bit hold, input int done_dly);
        for (int i = 0; i < 4; i++) req_flit[i] = 8'($urandom);
        req_vld = vld;
        tx_rdy  = 1'b1;
        #1 push_grant(vld);
        @(negedge clk);
        if (!hold) req_vld = '0;
        #1;
        chk("tx_vld_up", 32'(tx_vld), 1);
        pop_check();
        chk("rdy_in_send", 32'(req_rdy), 0);
        @(negedge clk);
        #1;
        chk("tx_vld_one", 32'(tx_vld), 0);
        chk("busy_wait", 32'(busy), 1);
        repeat (done_dly - 1) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        #1;
        for (int g = 0; g < GAP; g++) begin
            chk("gap_busy", 32'(busy), 1);
            chk("gap_rdy", 32'(req_rdy), 0);
            @(negedge clk);
            #1;
        end
        chk("gap_end", 32'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int order[5];
        types::flit_t f;
        order = '{0, 1, 2, 3, 0};
        #1 rst_n = 1'b0;
        #2;
        chk("rst_rdy", 32'(req_rdy), 0);
        chk("rst_tx_vld", 32'(tx_vld), 0);
        chk("rst_tx_flit", 32'(tx_flit), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        chk("rst_u1_timeout", 32'(r1_timeout_err), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        frame(4'b0100, 1'b0, 3);
        chk("grant_id_single", 32'(grant_id), 2);

        // abandon a frame in WAIT_DONE with an asynchronous reset
        req_vld = 4'b0010;
        #1 push_grant(4'b0010);
        @(negedge clk);
        req_vld = '0;
        #1 pop_check();
        @(negedge clk);
        #1 chk("pre_rst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("async_tx_vld", 32'(tx_vld), 0);
        chk("async_busy", 32'(busy), 0);
        chk("async_grant_id", 32'(grant_id), 0);
        @(negedge clk);
        rst_n = 1'b1;
        mdl_last = 3;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_timeout", 32'(timeout_err), 0);
            chk("post_rst_busy", 32'(busy), 0);
        end

        for (int i = 0; i < 5; i++) begin
            frame(4'b1111, i < 4, 3);
            chk("rr_order", 32'(grant_id), order[i]);
        end

        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        #1 chk("idle_done_ignored", 32'(busy), 0);

        // tx_rdy stall, then tx_done withheld until timeout
        for (int i = 0; i < 4; i++) req_flit[i] = 8'($urandom);
        req_vld = 4'b1000;
        tx_rdy  = 1'b0;
        w = pick(4'b1000);
        f = req_flit[2'(w)];
        #1 push_grant(4'b1000);
        @(negedge clk);
        req_vld = 4'b1111;
        #1 pop_check();
        for (int i = 0; i < 10; i++) begin
            if (i != 0) begin
                @(negedge clk);
                #1;
            end
            chk("stall_vld", 32'(tx_vld), 1);
            chk("stall_flit", 32'(tx_flit), 32'(f));
            chk("stall_rdy", 32'(req_rdy), 0);
            req_flit[2'(w)] = 8'($urandom);
        end
        tx_rdy = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("to_quiet", 32'(timeout_err), 0);
            chk("to_busy", 32'(busy), 1);
            @(negedge clk);
        end
        #1;
        chk("to_pulse", 32'(timeout_err), 1);
        chk("to_idle", 32'(busy), 0);
        push_grant(4'b1111);
        @(negedge clk);
        req_vld = '0;
        #1;
        chk("to_single", 32'(timeout_err), 0);
        chk("to_next_vld", 32'(tx_vld), 1);
        pop_check();
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk("to_frame_end", 32'(busy), 0);

        // zero gap: accept and done together
        for (int i = 0; i < 4; i++) r1_flit[i] = 8'($urandom);
        r1_vld = 4'b0011;
        #1 chk("nogap_rdy0", 32'(r1_rdy), 32'b0001);
        @(negedge clk);
        r1_tx_rdy  = 1'b1;
        r1_tx_done = 1'b1;
        #1;
        chk("nogap_vld", 32'(r1_tx_vld), 1);
        chk("nogap_flit", 32'(r1_tx_flit), 32'(r1_flit[0]));
        @(negedge clk);
        r1_tx_done = 1'b0;
        #1;
        chk("nogap_idle", 32'(r1_busy), 0);
        chk("nogap_rdy1", 32'(r1_rdy), 32'b0010);
        chk("nogap_gid_hold", 32'(r1_grant_id), 0);
        @(negedge clk);
        r1_vld = '0;
        #1;
        chk("nogap_vld2", 32'(r1_tx_vld), 1);
        chk("nogap_gid", 32'(r1_grant_id), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
